// File: rtl/clock_bcd_timekeeper_pkg.sv
// Shared types, field moduli and BCD helpers for the HH:MM:SS timekeeper.
//   SEC_MOD / MIN_MOD / HOUR_MOD : modulus of each time field
//   bcd_t                        : one BCD digit
//   bcd2_t                       : tens/ones BCD digit pair
//   bcd2bin / bcd2_valid         : convert and range-check a BCD pair
package clock_bcd_timekeeper_pkg;

   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HOUR_MOD = 24;

   typedef logic [3:0] bcd_t;
   typedef logic [7:0] bcd2_t;

   // Binary value of a BCD pair. Non-decimal digits give a meaningless
   // value, so callers must qualify the result with bcd2_valid.
   function automatic logic [6:0] bcd2bin(input bcd2_t v);
      return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
   endfunction

   function automatic logic bcd2_valid(input bcd2_t v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/clock_bcd_timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD (MOD <= 100).
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset, clears both digits
//   inc_i    : advance by one this cycle
//   tens_o   : tens digit
//   ones_o   : ones digit
//   wrap_o   : combinational, high in the cycle inc_i advances MOD-1 -> 0
module clock_bcd_timekeeper_bcd_mod_counter
   import clock_bcd_timekeeper_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inc_i,
   output bcd_t tens_o,
   output bcd_t ones_o,
   output logic wrap_o
);

   localparam bcd_t MAX_TENS = bcd_t'((MOD - 1) / 10);
   localparam bcd_t MAX_ONES = bcd_t'((MOD - 1) % 10);

   bcd_t tens_q, tens_d;
   bcd_t ones_q, ones_d;
   logic at_max;

   assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
   assign wrap_o = inc_i && at_max;

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (inc_i) begin
         if (at_max) begin
            tens_d = '0;
            ones_d = '0;
         end else if (ones_q == 4'd9) begin
            tens_d = tens_q + 4'd1;
            ones_d = '0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/clock_bcd_timekeeper.sv
// HH:MM:SS timekeeper with BCD digit outputs, set mode, 12/24-hour display,
// day-wrap pulse and HH:MM alarm match. Single clock domain; the 1 Hz tick
// is a clock enable derived from a prescaler.
//   clk, reset                   : system clock, synchronous active-high reset
//   settime                      : 1 = set mode (tick frozen, per-field increments)
//   upsec / upmin / uphour       : set-mode increment buttons, rising edge acts
//   mode12                       : 1 = 12-hour display mapping
//   alarm_en, alarm_hour/min     : alarm enable and BCD alarm time (24-h)
//   out{sec,min,hour}{MSB,LSB}   : BCD display digits
//   pm                           : internal hour >= 12
//   day_wrap                     : one-cycle pulse on 23:59:59 -> 00:00:00
//   alarm_match                  : one-cycle pulse when time reaches alarm HH:MM:00
module clock_bcd_timekeeper
   import clock_bcd_timekeeper_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       settime,
   input  logic       upsec,
   input  logic       upmin,
   input  logic       uphour,
   input  logic       mode12,
   input  logic       alarm_en,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_min,
   output logic [3:0] outsecMSB,
   output logic [3:0] outsecLSB,
   output logic [3:0] outminMSB,
   output logic [3:0] outminLSB,
   output logic [3:0] outhourMSB,
   output logic [3:0] outhourLSB,
   output logic       pm,
   output logic       day_wrap,
   output logic       alarm_match
);

   localparam int                TICK_W    = $clog2(TICK_DIV + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] presc_q, presc_d;
   logic              tick;
   logic [2:0]        up_q, up_lvl, up_rise;
   logic              sec_inc, min_inc, hour_inc;
   logic              sec_wrap, min_wrap, hour_wrap;
   bcd_t              sec_t, sec_o, min_t, min_o, hr_t, hr_o;
   bcd_t              disp_t, disp_o;
   logic [6:0]        hour_bin, min_bin, al_hour_bin, al_min_bin;
   logic [10:0]       cur_mins, next_mins, al_mins;
   logic              al_ok;
   logic              day_wrap_q, day_wrap_d;
   logic              alarm_match_q, alarm_match_d;

   // Prescaler: frozen at 0 in set mode so the first tick after leaving
   // set mode arrives a full TICK_DIV cycles later.
   assign tick = !settime && (presc_q == TICK_LAST);

   always_comb begin
      presc_d = '0;
      if (!settime && !tick) presc_d = presc_q + TICK_W'(1);
   end

   // Edge registers reset to 1 so a button held through reset is not
   // seen as a press.
   assign up_lvl  = {uphour, upmin, upsec};
   assign up_rise = up_lvl & ~up_q;

   // In set mode each field follows its own button and carries are dropped.
   assign sec_inc  = settime ? up_rise[0] : tick;
   assign min_inc  = settime ? up_rise[1] : sec_wrap;
   assign hour_inc = settime ? up_rise[2] : min_wrap;

   clock_bcd_timekeeper_bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
      .clk_i   (clk),
      .reset_i (reset),
      .inc_i   (sec_inc),
      .tens_o  (sec_t),
      .ones_o  (sec_o),
      .wrap_o  (sec_wrap)
   );

   clock_bcd_timekeeper_bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
      .clk_i   (clk),
      .reset_i (reset),
      .inc_i   (min_inc),
      .tens_o  (min_t),
      .ones_o  (min_o),
      .wrap_o  (min_wrap)
   );

   clock_bcd_timekeeper_bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
      .clk_i   (clk),
      .reset_i (reset),
      .inc_i   (hour_inc),
      .tens_o  (hr_t),
      .ones_o  (hr_o),
      .wrap_o  (hour_wrap)
   );

   // Alarm: a run-mode seconds wrap lands on HH:MM:00 of the *next* minute,
   // so compare the alarm against the current minute-of-day plus one.
   assign hour_bin    = bcd2bin({hr_t, hr_o});
   assign min_bin     = bcd2bin({min_t, min_o});
   assign al_hour_bin = bcd2bin(alarm_hour);
   assign al_min_bin  = bcd2bin(alarm_min);
   assign cur_mins    = (11'(hour_bin) * 11'd60) + 11'(min_bin);
   assign next_mins   = (cur_mins == 11'd1439) ? 11'd0 : cur_mins + 11'd1;
   assign al_mins     = (11'(al_hour_bin) * 11'd60) + 11'(al_min_bin);
   assign al_ok       = bcd2_valid(alarm_hour) && bcd2_valid(alarm_min) &&
                        (al_hour_bin < 7'd24) && (al_min_bin < 7'd60);

   assign alarm_match_d = alarm_en && al_ok && !settime && sec_wrap &&
                          (next_mins == al_mins);
   assign day_wrap_d    = !settime && hour_wrap;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q       <= '0;
         up_q          <= 3'b111;
         day_wrap_q    <= 1'b0;
         alarm_match_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         up_q          <= up_lvl;
         day_wrap_q    <= day_wrap_d;
         alarm_match_q <= alarm_match_d;
      end
   end

   // 12-hour mapping done directly on BCD digits:
   // 00 -> 12, 13..19 -> 1..7, 20..21 -> 8..9, 22..23 -> 10..11.
   always_comb begin
      disp_t = hr_t;
      disp_o = hr_o;
      if (mode12) begin
         if (hr_t == 4'd0 && hr_o == 4'd0) begin
            disp_t = 4'd1;
            disp_o = 4'd2;
         end else if (hr_t == 4'd1 && hr_o >= 4'd3) begin
            disp_t = 4'd0;
            disp_o = hr_o - 4'd2;
         end else if (hr_t == 4'd2 && hr_o <= 4'd1) begin
            disp_t = 4'd0;
            disp_o = hr_o + 4'd8;
         end else if (hr_t == 4'd2) begin
            disp_t = 4'd1;
            disp_o = hr_o - 4'd2;
         end
      end
   end

   assign outsecMSB   = sec_t;
   assign outsecLSB   = sec_o;
   assign outminMSB   = min_t;
   assign outminLSB   = min_o;
   assign outhourMSB  = disp_t;
   assign outhourLSB  = disp_o;
   assign pm          = (hr_t == 4'd2) || (hr_t == 4'd1 && hr_o >= 4'd2);
   assign day_wrap    = day_wrap_q;
   assign alarm_match = alarm_match_q;

endmodule

// File: tb/tb_clock_bcd_timekeeper.sv
module tb_clock_bcd_timekeeper;

   typedef struct packed {
      logic [3:0] sm, sl, mm, ml, hm, hl;
      logic       pm, dw, am;
   } obs_t;

   typedef struct packed {
      obs_t o0;
      obs_t o1;
   } pair_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, settime = 1'b0;
   logic       upsec = 1'b0, upmin = 1'b0, uphour = 1'b0;
   logic       mode12 = 1'b0, alarm_en = 1'b0;
   logic [7:0] alarm_hour = 8'h00, alarm_min = 8'h00;

   logic [3:0] o_sm [2], o_sl [2], o_mm [2], o_ml [2], o_hm [2], o_hl [2];
   logic       o_pm [2], o_dw [2], o_am [2];

   clock_bcd_timekeeper #(.TICK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .settime(settime),
      .upsec(upsec), .upmin(upmin), .uphour(uphour),
      .mode12(mode12), .alarm_en(alarm_en),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .outsecMSB(o_sm[0]), .outsecLSB(o_sl[0]),
      .outminMSB(o_mm[0]), .outminLSB(o_ml[0]),
      .outhourMSB(o_hm[0]), .outhourLSB(o_hl[0]),
      .pm(o_pm[0]), .day_wrap(o_dw[0]), .alarm_match(o_am[0])
   );

   clock_bcd_timekeeper #(.TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .settime(settime),
      .upsec(upsec), .upmin(upmin), .uphour(uphour),
      .mode12(mode12), .alarm_en(alarm_en),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .outsecMSB(o_sm[1]), .outsecLSB(o_sl[1]),
      .outminMSB(o_mm[1]), .outminLSB(o_ml[1]),
      .outhourMSB(o_hm[1]), .outhourLSB(o_hl[1]),
      .pm(o_pm[1]), .day_wrap(o_dw[1]), .alarm_match(o_am[1])
   );

   obs_t act0, act1;
   assign act0 = {o_sm[0], o_sl[0], o_mm[0], o_ml[0], o_hm[0], o_hl[0], o_pm[0], o_dw[0], o_am[0]};
   assign act1 = {o_sm[1], o_sl[1], o_mm[1], o_ml[1], o_hm[1], o_hl[1], o_pm[1], o_dw[1], o_am[1]};

   // Reference model: time as seconds-of-day, one per DUT instance.
   int       m_div [2] = '{4, 1};
   int       m_t   [2];
   int       m_cnt [2];
   logic     m_dw  [2];
   logic     m_am  [2];
   logic [2:0] m_prev = 3'b111;

   pair_t exp_q [$];
   pair_t mon_p;
   int    errors = 0;
   int    checks = 0;

   function automatic int bcd_val(input logic [7:0] b);
      int hi, lo;
      hi = int'(b[7:4]);
      lo = int'(b[3:0]);
      if (hi > 9 || lo > 9) return -1;
      return hi * 10 + lo;
   endfunction

   function automatic obs_t expect_obs(input int tt, input logic m12,
                                       input logic dw, input logic am);
      obs_t o;
      int h, m, s, dh;
      h  = tt / 3600;
      m  = (tt / 60) % 60;
      s  = tt % 60;
      dh = m12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
      o.sm = 4'(s / 10);  o.sl = 4'(s % 10);
      o.mm = 4'(m / 10);  o.ml = 4'(m % 10);
      o.hm = 4'(dh / 10); o.hl = 4'(dh % 10);
      o.pm = (h >= 12);
      o.dw = dw;
      o.am = am;
      return o;
   endfunction

   task automatic model_update();
      logic [2:0] lv, rise;
      int hh, mm, ss, ah, amv;
      pair_t p;
      lv   = {uphour, upmin, upsec};
      rise = lv & ~m_prev;
      ah   = bcd_val(alarm_hour);
      amv  = bcd_val(alarm_min);
      for (int k = 0; k < 2; k++) begin
         m_dw[k] = 1'b0;
         m_am[k] = 1'b0;
         if (reset) begin
            m_t[k]   = 0;
            m_cnt[k] = 0;
         end else if (settime) begin
            m_cnt[k] = 0;
            hh = m_t[k] / 3600;
            mm = (m_t[k] / 60) % 60;
            ss = m_t[k] % 60;
            if (rise[0]) ss = (ss + 1) % 60;
            if (rise[1]) mm = (mm + 1) % 60;
            if (rise[2]) hh = (hh + 1) % 24;
            m_t[k] = hh * 3600 + mm * 60 + ss;
         end else if (m_cnt[k] == m_div[k] - 1) begin
            m_cnt[k] = 0;
            m_t[k]   = (m_t[k] + 1) % 86400;
            m_dw[k]  = (m_t[k] == 0);
            m_am[k]  = alarm_en && ah >= 0 && ah < 24 && amv >= 0 && amv < 60 &&
                       (m_t[k] == ah * 3600 + amv * 60);
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
         end
      end
      m_prev = reset ? 3'b111 : lv;
      p.o0 = expect_obs(m_t[0], mode12, m_dw[0], m_am[0]);
      p.o1 = expect_obs(m_t[1], mode12, m_dw[1], m_am[1]);
      exp_q.push_back(p);
   endtask

   task automatic chk(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t got hh:mm:ss=%h%h:%h%h:%h%h pm=%b dw=%b am=%b required %h%h:%h%h:%h%h pm=%b dw=%b am=%b",
                  name, $time, act.hm, act.hl, act.mm, act.ml, act.sm, act.sl, act.pm, act.dw, act.am,
                  exp.hm, exp.hl, exp.mm, exp.ml, exp.sm, exp.sl, exp.pm, exp.dw, exp.am);
      end
   endtask

   // Monitor: every clock presents a new output word; compare it against the
   // oldest expectation queued by the stimulus side.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_p = exp_q.pop_front();
         chk("div4", act0, mon_p.o0);
         chk("div1", act1, mon_p.o1);
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      upsec = 1'b0; upmin = 1'b0; uphour = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic press(input bit s, input bit m, input bit h);
      upsec = s; upmin = m; uphour = h;
      step();
      upsec = 1'b0; upmin = 1'b0; uphour = 1'b0;
      step();
   endtask

   task automatic set_time(input int h, input int m, input int s);
      int n;
      do_reset();
      settime = 1'b1;
      step();
      n = (h > m) ? h : m;
      n = (n > s) ? n : s;
      for (int i = 0; i < n; i++) press(i < s, i < m, i < h);
   endtask

   initial begin
      // Reset state and first-tick latency, both display modes.
      mode12 = 1'b0;
      do_reset();
      repeat (8) step();
      mode12 = 1'b1;
      do_reset();
      repeat (3) step();
      mode12 = 1'b0;

      // Day wrap from 23:59:59.
      set_time(23, 59, 59);
      settime = 1'b0;
      repeat (6) step();

      // Held button gives one increment; set-mode wraps do not carry.
      do_reset();
      settime = 1'b1;
      upsec = 1'b1;
      repeat (10) step();
      upsec = 1'b0;
      step();
      set_time(0, 0, 59);
      press(1, 0, 0);
      set_time(23, 59, 59);
      press(1, 1, 1);
      step();

      // 12/24-hour mapping.
      set_time(13, 5, 0);
      mode12 = 1'b1; step(); step();
      mode12 = 1'b0; step();
      set_time(0, 0, 0);
      mode12 = 1'b1; step(); step();
      set_time(22, 0, 0);
      step();
      mode12 = 1'b0;

      // Alarm enabled / disabled.
      alarm_hour = 8'h07; alarm_min = 8'h30; alarm_en = 1'b1;
      set_time(7, 29, 59);
      settime = 1'b0;
      repeat (6) step();
      alarm_en = 1'b0;
      set_time(7, 29, 59);
      settime = 1'b0;
      repeat (6) step();

      // Alarm at midnight coincides with day wrap; non-decimal BCD never matches.
      alarm_hour = 8'h00; alarm_min = 8'h00; alarm_en = 1'b1;
      set_time(23, 59, 59);
      settime = 1'b0;
      repeat (5) step();
      alarm_hour = 8'h1A; alarm_min = 8'h00;
      set_time(19, 59, 59);
      settime = 1'b0;
      repeat (5) step();

      // Reset in the tick cycle while upmin rises.
      alarm_hour = 8'h00; alarm_min = 8'h00;
      set_time(23, 59, 59);
      settime = 1'b0;
      repeat (3) step();
      reset = 1'b1; upmin = 1'b1;
      step();
      reset = 1'b0; upmin = 1'b0;
      repeat (6) step();

      // Randomised run.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         reset  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) settime = ~settime;
         if ($urandom_range(0, 29) == 0) mode12  = ~mode12;
         if ($urandom_range(0, 99) == 0) begin
            alarm_en   = $urandom_range(0, 1);
            alarm_hour = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            alarm_min  = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
         end
         upsec  = ($urandom_range(0, 2) == 0);
         upmin  = ($urandom_range(0, 2) == 0);
         uphour = ($urandom_range(0, 2) == 0);
         step();
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
